// File: rtl/object_bank.sv
// Multi-port object record store: four 2-cycle read ports, one write port,
// and a sequential zeroing sweep after reset or on clear_in.

module object_bank_lane #(
  parameter int OBJ_COUNT = 8,
  parameter int AW        = 7,
  parameter int IW        = 3,
  parameter int REC_W     = 103
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req_vld,
  input  logic [AW-1:0]    req_addr,
  output logic [IW-1:0]    rd_idx,
  input  logic [REC_W-1:0] rd_data,
  output logic             rsp_vld,
  output logic [REC_W-1:0] rsp_data,
  output logic             oob_hit
);
  localparam int STAGES = 2;

  logic [STAGES:0]    vld_pipe_q, vld_pipe_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               oob1_q, oob1_d, oob2_q, oob2_d;
  logic [REC_W-1:0]   data_q, data_d, rsp_q, rsp_d;
  logic               in_range;

  // Stage 0 samples the request; memory is read one edge later, so any write or
  // sweep step landing on the sampling edge is already in the array.
  always_comb begin
    in_range   = {1'b0, req_addr} < (AW+1)'(OBJ_COUNT);
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], req_vld};
    idx_d      = in_range ? req_addr[IW-1:0] : '0;
    oob1_d     = ~in_range;
    oob2_d     = oob1_q;
    data_d     = oob1_q ? '0 : rd_data;
    rsp_d      = vld_pipe_q[1] ? data_q : rsp_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_pipe_q <= '0;
      idx_q      <= '0;
      oob1_q     <= 1'b0;
      oob2_q     <= 1'b0;
      data_q     <= '0;
      rsp_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_q      <= idx_d;
      oob1_q     <= oob1_d;
      oob2_q     <= oob2_d;
      data_q     <= data_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rd_idx   = idx_q;
  assign rsp_vld  = vld_pipe_q[STAGES];
  assign rsp_data = rsp_q;
  assign oob_hit  = vld_pipe_q[1] & oob2_q;
endmodule

module object_bank #(
  parameter int OBJ_COUNT = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  clear_in,
  output logic                  busy_out,
  input  logic                  write_valid_in,
  input  logic [6:0]            save_addr_in,
  input  logic                  is_static_in,
  input  logic [1:0]            id_bits_in,
  input  logic [35:0]           params_in,
  input  logic [15:0]           pos_x_in,
  input  logic [15:0]           pos_y_in,
  input  logic [15:0]           vel_x_in,
  input  logic [15:0]           vel_y_in,
  input  logic [3:0]            read_valid_in,
  input  logic [3:0][6:0]       load_addr_in,
  output logic [3:0]            is_static_out,
  output logic [3:0][1:0]       id_bits_out,
  output logic [3:0][35:0]      params_out,
  output logic [3:0][15:0]      pos_x_out,
  output logic [3:0][15:0]      pos_y_out,
  output logic [3:0][15:0]      vel_x_out,
  output logic [3:0][15:0]      vel_y_out,
  output logic [3:0]            is_valid_out,
  output logic                  addr_err_out
);
  localparam int NUM_LANES = 4;
  localparam int AW        = 7;
  localparam int IW        = (OBJ_COUNT > 1) ? $clog2(OBJ_COUNT) : 1;
  localparam int REC_W     = 103;

  typedef struct packed {
    logic        is_static;
    logic [1:0]  id_bits;
    logic [35:0] params;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] vel_x;
    logic [15:0] vel_y;
  } rec_t;

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                      state_q;
  logic [AW-1:0]               clr_idx_q, clr_eff;
  logic                        busy_q;
  logic                        err_q, err_d;
  rec_t                        mem_q [OBJ_COUNT];
  logic                        mem_we, wr_err;
  logic [IW-1:0]               mem_widx;
  rec_t                        mem_wdata;

  logic [NUM_LANES-1:0][IW-1:0] rd_idx;
  rec_t [NUM_LANES-1:0]         rd_data, rsp_data;
  logic [NUM_LANES-1:0]         rsp_vld, oob_hit;

  // A clear during the sweep restarts it, and that same edge already zeroes entry 0.
  always_comb begin
    clr_eff   = clear_in ? '0 : clr_idx_q;
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    wr_err    = 1'b0;
    if (state_q == CLEARING) begin
      mem_we   = 1'b1;
      mem_widx = clr_eff[IW-1:0];
    end else if (write_valid_in) begin
      if ({1'b0, save_addr_in} < (AW+1)'(OBJ_COUNT)) begin
        mem_we              = 1'b1;
        mem_widx            = save_addr_in[IW-1:0];
        mem_wdata.is_static = is_static_in;
        mem_wdata.id_bits   = id_bits_in;
        mem_wdata.params    = params_in;
        mem_wdata.pos_x     = pos_x_in;
        mem_wdata.pos_y     = pos_y_in;
        mem_wdata.vel_x     = vel_x_in;
        mem_wdata.vel_y     = vel_y_in;
      end else begin
        wr_err = 1'b1;
      end
    end
    err_d = wr_err | (|oob_hit);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= CLEARING;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEARING: begin
          if (clr_eff == AW'(OBJ_COUNT - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_eff + AW'(1);
          end
        end
        default: begin
          if (clear_in) begin
            state_q   <= CLEARING;
            busy_q    <= 1'b1;
            clr_idx_q <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  // Storage is not reset; the post-reset sweep zeroes it.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) rd_data[k] = mem_q[rd_idx[k]];
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    object_bank_lane #(
      .OBJ_COUNT(OBJ_COUNT), .AW(AW), .IW(IW), .REC_W(REC_W)
    ) u_lane (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .req_vld  (read_valid_in[k]),
      .req_addr (load_addr_in[k]),
      .rd_idx   (rd_idx[k]),
      .rd_data  (rd_data[k]),
      .rsp_vld  (rsp_vld[k]),
      .rsp_data (rsp_data[k]),
      .oob_hit  (oob_hit[k])
    );

    assign is_static_out[k] = rsp_data[k].is_static;
    assign id_bits_out[k]   = rsp_data[k].id_bits;
    assign params_out[k]    = rsp_data[k].params;
    assign pos_x_out[k]     = rsp_data[k].pos_x;
    assign pos_y_out[k]     = rsp_data[k].pos_y;
    assign vel_x_out[k]     = rsp_data[k].vel_x;
    assign vel_y_out[k]     = rsp_data[k].vel_y;
  end

  assign is_valid_out = rsp_vld;
  assign busy_out     = busy_q;
  assign addr_err_out = err_q;
endmodule

// File: tb/tb_object_bank.sv
// Randomized and directed bench for object_bank against an array/delay-line
// model of the store, plus literal expectations for the documented scenarios.

module tb_object_bank;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_in, write_valid_in, is_static_in;
  logic [6:0] save_addr_in;
  logic [1:0] id_bits_in;
  logic [35:0] params_in;
  logic [15:0] pos_x_in, pos_y_in, vel_x_in, vel_y_in;
  logic [3:0] read_valid_in;
  logic [3:0][6:0] load_addr_in;
  logic busy_out, addr_err_out;
  logic [3:0] is_static_out, is_valid_out;
  logic [3:0][1:0] id_bits_out;
  logic [3:0][35:0] params_out;
  logic [3:0][15:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;

  int n_chk = 0, n_pass = 0;
  int cnt, errs;

  always #5 clk = ~clk;

  object_bank #(.OBJ_COUNT(N)) dut (
    .sys_clk(clk), .sys_rst(rst), .clear_in(clear_in), .busy_out(busy_out),
    .write_valid_in(write_valid_in), .save_addr_in(save_addr_in),
    .is_static_in(is_static_in), .id_bits_in(id_bits_in), .params_in(params_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .read_valid_in(read_valid_in), .load_addr_in(load_addr_in),
    .is_static_out(is_static_out), .id_bits_out(id_bits_out), .params_out(params_out),
    .pos_x_out(pos_x_out), .pos_y_out(pos_y_out), .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
    .is_valid_out(is_valid_out), .addr_err_out(addr_err_out)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [102:0] wr_rec();
    return {is_static_in, id_bits_in, params_in, pos_x_in, pos_y_in, vel_x_in, vel_y_in};
  endfunction

  function automatic logic [102:0] out_rec(input int k);
    return {is_static_out[k], id_bits_out[k], params_out[k], pos_x_out[k],
            pos_y_out[k], vel_x_out[k], vel_y_out[k]};
  endfunction

  // ---------------- reference model ----------------
  logic [102:0] m_mem [N];
  logic         m_busy;
  int           m_idx;
  logic [3:0]   p0_v, p1_v, p0_o, p1_o, e_vld;
  logic [102:0] p0_d [4];
  logic [102:0] p1_d [4];
  logic [102:0] e_data [4];
  logic         e_err;

  initial for (int i = 0; i < N; i++) m_mem[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b1; m_idx = 0;
      p0_v = '0; p1_v = '0; p0_o = '0; p1_o = '0;
      e_vld = '0; e_err = 1'b0;
      for (int k = 0; k < 4; k++) begin e_data[k] = '0; p0_d[k] = '0; p1_d[k] = '0; end
    end else begin
      // responses for requests sampled two edges ago
      e_vld = p1_v;
      e_err = |(p1_v & p1_o);
      for (int k = 0; k < 4; k++) if (p1_v[k]) e_data[k] = p1_d[k];
      p1_v = p0_v; p1_o = p0_o;
      for (int k = 0; k < 4; k++) p1_d[k] = p0_d[k];
      if (m_busy) begin
        if (clear_in) m_idx = 0;
        m_mem[m_idx] = '0;
        if (m_idx == N - 1) m_busy = 1'b0;
        else m_idx++;
      end else begin
        if (write_valid_in) begin
          if (int'(save_addr_in) < N) m_mem[int'(save_addr_in)] = wr_rec();
          else e_err = 1'b1;
        end
        if (clear_in) begin m_busy = 1'b1; m_idx = 0; end
      end
      // reads sampled now see the array after this edge's write / sweep step
      for (int k = 0; k < 4; k++) begin
        p0_v[k] = read_valid_in[k];
        p0_o[k] = int'(load_addr_in[k]) >= N;
        p0_d[k] = p0_o[k] ? '0 : m_mem[int'(load_addr_in[k])];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy_out, m_busy);
      chk("valid", is_valid_out, e_vld);
      chk("addr_err", addr_err_out, e_err);
      for (int k = 0; k < 4; k++) chk("data", out_rec(k), e_data[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int a, input logic st, input logic [1:0] id, input logic [35:0] prm,
                        input logic [15:0] px, input logic [15:0] py,
                        input logic [15:0] vx, input logic [15:0] vy);
    write_valid_in = 1'b1; save_addr_in = 7'(a); is_static_in = st; id_bits_in = id;
    params_in = prm; pos_x_in = px; pos_y_in = py; vel_x_in = vx; vel_y_in = vy;
  endtask

  task automatic read4(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
    read_valid_in = v;
    load_addr_in[0] = 7'(a0); load_addr_in[1] = 7'(a1);
    load_addr_in[2] = 7'(a2); load_addr_in[3] = 7'(a3);
    tick();
    read_valid_in = '0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy_out && c < 100) begin tick(); c++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_in = 0; write_valid_in = 0; save_addr_in = '0; is_static_in = 0; id_bits_in = '0;
    params_in = '0; pos_x_in = '0; pos_y_in = '0; vel_x_in = '0; vel_y_in = '0;
    read_valid_in = '0; load_addr_in = '0;
    tick(); tick();
    chk("rst_busy", busy_out, 1'b1);
    chk("rst_valid", is_valid_out, 4'h0);
    chk("rst_err", addr_err_out, 1'b0);
    chk("rst_data", out_rec(0), 103'h0);
    rst = 1'b0;
    wait_idle(cnt);
    chk("rst_busy_len", cnt, 8);

    // every entry reads back zero after the sweep
    read4(4'hf, 0, 1, 2, 3);
    read4(4'hf, 4, 5, 6, 7);
    tick(); chk("zero_vld_a", is_valid_out, 4'hf); chk("zero_prm_a", params_out, 144'h0);
    tick(); chk("zero_vld_b", is_valid_out, 4'hf); chk("zero_pos_b", pos_x_out, 64'h0);
    tick(); chk("zero_vld_end", is_valid_out, 4'h0);

    // write entry 3, read it on all ports
    set_wr(3, 1'b1, 2'd2, 36'h123456789, 16'h0123, 16'h0040, 16'hFFC0, 16'hFFE0);
    tick(); write_valid_in = 0;
    read4(4'hf, 3, 3, 3, 3);
    tick(); chk("t2_early", is_valid_out, 4'h0);
    tick(); chk("t2_vld", is_valid_out, 4'hf);
    chk("t2_posx", pos_x_out, {4{16'h0123}});
    chk("t2_vely", vel_y_out, {4{16'hFFE0}});
    chk("t2_static", is_static_out, 4'hf);
    tick(); chk("t2_one_wide", is_valid_out, 4'h0);

    // write-first bypass
    set_wr(5, 1'b0, 2'd1, 36'h0000AAAAA, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    read_valid_in = 4'b0010; load_addr_in[1] = 7'd5;
    tick();
    set_wr(5, 1'b0, 2'd3, 36'h0000BBBBB, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    read_valid_in = 4'b0100; load_addr_in[2] = 7'd5;
    tick(); write_valid_in = 0; read_valid_in = '0;
    tick(); chk("byp_a_vld", is_valid_out, 4'b0010); chk("byp_a", params_out[1], 36'h0000AAAAA);
    tick(); chk("byp_b_vld", is_valid_out, 4'b0100); chk("byp_b", params_out[2], 36'h0000BBBBB);

    // out-of-range read and write
    set_wr(12, 1'b1, 2'd3, 36'hFFFFFFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    read_valid_in = 4'b0001; load_addr_in[0] = 7'd9;
    errs = 0;
    tick(); errs += int'(addr_err_out); write_valid_in = 0; read_valid_in = '0;
    tick(); errs += int'(addr_err_out);
    tick(); errs += int'(addr_err_out);
    chk("oob_vld", is_valid_out, 4'b0001); chk("oob_data", out_rec(0), 103'h0);
    tick(); errs += int'(addr_err_out);
    chk("oob_err_pulses", errs, 2);
    read4(4'b0001, 4, 0, 0, 0);
    tick(); tick(); chk("oob_no_alias", out_rec(0), 103'h0);

    // fill, then back-to-back reads on port 0
    for (int i = 0; i < N; i++) begin
      set_wr(i, 1'b0, 2'd0, 36'(i * 3 + 1), 16'(i), 16'h0, 16'h0, 16'h0);
      tick();
    end
    write_valid_in = 0;
    for (int t = 0; t < 10; t++) begin
      read_valid_in = (t < 8) ? 4'b0001 : 4'b0000;
      load_addr_in[0] = 7'(t);
      tick();
      if (t >= 2) begin
        chk("b2b_vld", is_valid_out, 4'b0001);
        chk("b2b_prm", params_out[0], 36'((t - 2) * 3 + 1));
      end else begin
        chk("b2b_lat", is_valid_out, 4'b0000);
      end
    end
    read_valid_in = '0;

    // clear, restart at clr_idx=4 with a dropped write
    clear_in = 1; tick(); clear_in = 0;
    cnt = 0;
    repeat (4) begin tick(); cnt++; end
    clear_in = 1;
    set_wr(6, 1'b1, 2'd1, 36'h00000DEAD, 16'h1, 16'h1, 16'h1, 16'h1);
    tick(); cnt++; clear_in = 0; write_valid_in = 0;
    while (busy_out && cnt < 100) begin tick(); cnt++; end
    chk("clr_busy_len", cnt, 12);
    read4(4'hf, 0, 1, 2, 3);
    read4(4'hf, 4, 5, 6, 7);
    tick(); chk("clr_zero_a", params_out, 144'h0); chk("clr_zero_a_px", pos_x_out, 64'h0);
    tick(); chk("clr_zero_b", params_out, 144'h0); chk("clr_zero_b_st", is_static_out, 4'h0);

    // reset with reads in flight
    read4(4'b0001, 1, 0, 0, 0);
    read4(4'b0010, 0, 2, 0, 0);
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy_out, 1'b1);
    chk("mid_rst_vld", is_valid_out, 4'h0);
    repeat (3) begin tick(); chk("mid_rst_flush", is_valid_out, 4'h0); end
    rst = 1'b0;
    wait_idle(cnt);
    chk("rst2_busy_len", cnt, 8);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      write_valid_in = 1'($urandom_range(0, 1));
      save_addr_in = 7'($urandom_range(0, 10));
      is_static_in = 1'($urandom); id_bits_in = 2'($urandom);
      params_in = {4'($urandom), 32'($urandom)};
      pos_x_in = 16'($urandom); pos_y_in = 16'($urandom);
      vel_x_in = 16'($urandom); vel_y_in = 16'($urandom);
      read_valid_in = 4'($urandom);
      for (int k = 0; k < 4; k++) load_addr_in[k] = 7'($urandom_range(0, 9));
      clear_in = ($urandom_range(0, 59) == 0);
      tick();
    end
    clear_in = 0; write_valid_in = 0; read_valid_in = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/object_bank.md
# object_bank

Multi-port object store that answers the physics engine's LOADING and SAVING traffic. It holds one packed 103-bit record per object. It serves up to four independent read requests per cycle with a fixed two-cycle latency and accepts one write per cycle. It also runs a sequential clear sweep after reset or on command. The block sits between the physics engine and the rendering/camera side, as the single source of truth for object state between frames.

## Interface
- OBJ_COUNT, 8, number of stored records; legal range 1..128
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- clear_in  in  1  pulse: start zeroing sweep
- busy_out  out  1  high while clear sweep runs
- write_valid_in  in  1  write strobe
- save_addr_in  in  7  write address
- is_static_in  in  1  write data field
- id_bits_in  in  2  write data field
- params_in  in  36  write data field
- pos_x_in, pos_y_in, vel_x_in, vel_y_in  in  16 each  write data fields, signed fixed point, 5 fractional bits
- read_valid_in  in  [3:0]  per-port read strobe
- load_addr_in  in  [3:0][6:0]  per-port read address
- is_static_out  out  [3:0]  per-port read data
- id_bits_out  out  [3:0][1:0]  per-port read data
- params_out  out  [3:0][35:0]  per-port read data
- pos_x_out, pos_y_out, vel_x_out, vel_y_out  out  [3:0][15:0] each  per-port read data
- is_valid_out  out  [3:0]  per-port response strobe
- addr_err_out  out  1  one-cycle pulse on any out-of-range access

## Operation
- Record packing, MSB to LSB: {is_static, id_bits, params, pos_x, pos_y, vel_x, vel_y}, 103 bits. The low 64 bits are the dynamic part.
- FSM states:
  - CLEARING. Entered from reset or from IDLE on clear_in. Writes zero to entry clr_idx each cycle, incrementing clr_idx from 0. After entry OBJ_COUNT-1 is written, goes to IDLE.
  - IDLE. Normal service.
- clear_in during CLEARING restarts the sweep at clr_idx=0.
- busy_out = (state==CLEARING).
- Writes:
  - In IDLE with write_valid_in=1 and save_addr_in<OBJ_COUNT, the record is stored at the clock edge.
  - In CLEARING, write_valid_in is ignored with no error.
- Reads:
  - Each port k is independent. A request on port k with read_valid_in[k]=1 enters a 2-stage pipeline and is served in both states.
  - During CLEARING, reads return current contents, which may be partly zeroed.
- Write-first bypass: if a read in cycle N addresses the entry written in cycle N, the response carries the newly written data. The same applies to the entry being zeroed by the sweep.
- Out of range (address >= OBJ_COUNT):
  - A read still responds with is_valid_out[k]=1 and all-zero data.
  - A write is dropped.
  - Either case raises addr_err_out, aligned with the response cycle for reads and the cycle after the strobe for writes.
- Several ports may read the same address in the same cycle; all return identical data.

## Timing
- Reset values:
  - state=CLEARING, clr_idx=0, busy_out=1.
  - All is_valid_out=0, addr_err_out=0, all data outputs 0, pipeline valid bits cleared.
- After sys_rst deasserts, busy_out stays high for exactly OBJ_COUNT cycles.
- Read latency: request sampled at edge N produces data and is_valid_out[k]=1 during the cycle after edge N+2 (two register stages).
  - is_valid_out[k] is high for exactly one cycle per request.
  - Data outputs hold their last value when not valid.
- Throughput: one request per port per cycle, fully pipelined, with no stalls or backpressure.
- Write visibility:
  - A write at edge N is visible to a read sampled at edge N (bypass) or later.
  - A read sampled at edge N-1 returns old data.
- Clear sweep: OBJ_COUNT cycles; the entry zeroed at edge N is visible, via bypass, to reads sampled at edge N.
- sys_rst asserted mid-pipeline flushes all in-flight reads; no is_valid_out pulse follows for them.

## Test plan
- Reset, then 8 idle cycles with OBJ_COUNT=8: busy_out goes high→low after exactly 8 cycles. Reads of all 8 entries return zeros with is_valid_out pulses at +2.
- Write entry 3 with pos_x=0x0123, vel_y=0xFFE0, is_static=1, then read entry 3 on all four ports in the next cycle: all ports return identical fields, is_valid_out=4'b1111 two cycles later, one cycle wide.
- Write entry 5 = A, then in one cycle write entry 5 = B while port 2 reads entry 5: port 2 returns B (bypass). A read issued in the cycle before returns A.
- Read address 9 and write address 12 with OBJ_COUNT=8: read returns zeros with is_valid_out set. addr_err_out pulses twice. No stored entry changes.
- Back-to-back reads on port 0 of addresses 0..7 on consecutive cycles: 8 consecutive valid responses in order, starting 2 cycles after the first request.
- After filling entries, pulse clear_in, then pulse it again mid-sweep at clr_idx=4: busy_out stays high 4+8 cycles total. Writes during the sweep are dropped. All entries are zero afterward.
- Assert sys_rst with two reads in flight: no is_valid_out pulse follows, and busy_out=1 immediately.
